conv1d_mac: RTL and testbench

//  Downstream consumer of the N-tap pixel window shift register: multiplies each window tap by a

---
 rtl/conv1d_mac.sv | 143 ++++++++++++++
 tb/tb_conv1d_mac.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_mac.sv
// rtl/conv1d_mac.sv - N-tap signed-kernel MAC with normalise/clamp, 3-stage valid/ready pipeline
// Optional build macro: CONV_ROUND_EN (round half up before the normalising shift)
module conv1d_mac #(
  parameter int N     = 11,
  parameter int B     = 8,
  parameter int C     = 8,
  parameter int SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [B-1:0]         win [N-1:0],
  input  logic                 win_valid,
  output logic                 win_ready,
  input  logic                 coef_we,
  input  logic [$clog2(N)-1:0] coef_addr,
  input  logic signed [C-1:0]  coef_wdata,
  input  logic                 coef_swap,
  output logic [B-1:0]         out_pix,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Product width: unsigned pixel with a zero sign bit times a signed coefficient.
  localparam int PW    = B + C + 1;
  // Sum of N products cannot overflow with clog2(N) guard bits.
  localparam int ACC_W = PW + $clog2(N);
  // One extra bit so the optional rounding add cannot wrap.
  localparam int RW    = ACC_W + 1;
  localparam int MAXP  = (2 ** B) - 1;

  logic signed [C-1:0]     coef_sh  [N];
  logic signed [C-1:0]     coef_act [N];
  logic signed [PW-1:0]    prod_n   [N];
  logic signed [PW-1:0]    prod_q   [N];
  logic signed [ACC_W-1:0] acc_n;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [RW-1:0]    acc_x;
  logic signed [RW-1:0]    shifted;
  logic [B-1:0]            pix_n;
  logic                    v1_q;
  logic                    v2_q;
  logic                    adv;

  // The whole pipeline freezes only when a finished result is waiting on downstream.
  assign adv       = !(out_valid && !out_ready);
  assign win_ready = adv && !rst;

  // Pixel is treated as non-negative; coefficient is sign-extended to the product width.
  function automatic logic signed [PW-1:0] tap_mul(input logic [B-1:0] pix,
                                                   input logic signed [C-1:0] cf);
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    a = $signed({{(PW-B){1'b0}}, pix});
    b = $signed({{(PW-C){cf[C-1]}}, cf});
    return a * b;
  endfunction

  // Shadow bank takes writes; swap copies the pre-write shadow into the active bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        coef_sh[k]  <= '0;
        coef_act[k] <= '0;
      end
    end else begin
      if (coef_swap) begin
        for (int k = 0; k < N; k++) begin
          coef_act[k] <= coef_sh[k];
        end
      end
      if (coef_we && (int'(coef_addr) < N)) begin
        coef_sh[coef_addr] <= coef_wdata;
      end
    end
  end

  // Stage 1 combinational: per-tap products against the bank active this cycle.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      prod_n[k] = tap_mul(win[k], coef_act[k]);
    end
  end

  // Stage 2 combinational: sign-extended sum of the registered products.
  always_comb begin
    acc_n = '0;
    for (int k = 0; k < N; k++) begin
      acc_n = acc_n + $signed({{(ACC_W-PW){prod_q[k][PW-1]}}, prod_q[k]});
    end
  end

`ifdef CONV_ROUND_EN
  localparam int RND = (SHIFT > 0) ? (2 ** (SHIFT - 1)) : 0;
`endif

  // Stage 3 combinational: optional round, arithmetic shift, clamp to the pixel range.
  always_comb begin
    acc_x = $signed({acc_q[ACC_W-1], acc_q});
`ifdef CONV_ROUND_EN
    acc_x = acc_x + RW'(RND);
`endif
    shifted = acc_x >>> SHIFT;
    if (shifted < 0) begin
      pix_n = '0;
    end else if (shifted > RW'(MAXP)) begin
      pix_n = '1;
    end else begin
      pix_n = shifted[B-1:0];
    end
  end

  // Valid bits and the output register; bubbles advance like data and are never collapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_valid <= 1'b0;
      out_pix   <= '0;
    end else if (adv) begin
      v1_q      <= win_valid;
      v2_q      <= v1_q;
      out_valid <= v2_q;
      if (v2_q) begin
        out_pix <= pix_n;
      end
    end
  end

  // Datapath registers need no reset: their contents are ignored unless the matching valid is set.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (win_valid) begin
        for (int k = 0; k < N; k++) begin
          prod_q[k] <= prod_n[k];
        end
      end
      if (v1_q) begin
        acc_q <= acc_n;
      end
    end
  end

endmodule

// File: tb/tb_conv1d_mac.sv
// tb/tb_conv1d_mac.sv - scoreboard bench for conv1d_mac with randomized and directed stimulus
module tb_conv1d_mac;
  localparam int N     = 11;
  localparam int B     = 8;
  localparam int C     = 8;
  localparam int SHIFT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [B-1:0] win [N-1:0];
  logic         win_valid;
  logic         win_ready;
  logic         coef_we;
  logic [3:0]   coef_addr;
  logic [C-1:0] coef_wdata;
  logic         coef_swap;
  logic [B-1:0] out_pix;
  logic         out_valid;
  logic         out_ready;

  conv1d_mac #(.N(N), .B(B), .C(C), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .win(win), .win_valid(win_valid), .win_ready(win_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_swap(coef_swap),
    .out_pix(out_pix), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int sh_m[N];
  int act_m[N];
  int delivered = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer dot product, optional round, floor shift, clamp.
  function automatic int model_pix(input int w[N], input int c[N]);
    int acc;
    acc = 0;
    for (int k = 0; k < N; k++) acc += w[k] * c[k];
`ifdef CONV_ROUND_EN
    if (SHIFT > 0) acc += 2 ** (SHIFT - 1);
`endif
    acc = acc >>> SHIFT;
    if (acc < 0) acc = 0;
    if (acc > 255) acc = 255;
    return acc;
  endfunction

  // Scoreboard: consume at output handshakes, predict at input handshakes, track coefficient banks.
  always @(negedge clk) begin
    int w[N];
    int e;
    if (out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_out: out_valid=1 out_pix=%0d with no result expected", out_pix);
      end else begin
        e = exp_q.pop_front();
        check("out_pix", 32'(out_pix), e);
        delivered++;
      end
    end
    if (win_valid && win_ready === 1'b1) begin
      for (int k = 0; k < N; k++) w[k] = int'(win[k]);
      exp_q.push_back(model_pix(w, act_m));
    end
    if (rst) begin
      exp_q.delete();
      for (int k = 0; k < N; k++) begin
        sh_m[k]  = 0;
        act_m[k] = 0;
      end
    end else begin
      if (coef_swap) act_m = sh_m;
      if (coef_we && int'(coef_addr) < N) sh_m[coef_addr] = int'($signed(coef_wdata));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int v);
    coef_we    = 1'b1;
    coef_addr  = a[3:0];
    coef_wdata = v[7:0];
    tick();
    coef_we = 1'b0;
  endtask

  task automatic load_kernel(input int k[N]);
    for (int i = 0; i < N; i++) wr(i, k[i]);
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
  endtask

  task automatic set_win(input int w[N]);
    for (int i = 0; i < N; i++) win[i] = B'(w[i]);
  endtask

  task automatic send(input int w[N]);
    logic got;
    got = 1'b0;
    set_win(w);
    win_valid = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      got = win_ready;
      tick();
    end
    win_valid = 1'b0;
    check("send_accepted", 32'(got), 1);
  endtask

  task automatic run_one(input int w[N], output logic [7:0] pix);
    send(w);
    for (int t = 0; t < 50 && out_valid !== 1'b1; t++) tick();
    check("run_one_valid", 32'(out_valid), 1);
    pix = out_pix;
    tick();
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int kern[N];
    int w[N];
    int got_pix[8];
    int ng;
    int idx;
    int d0;
    int held;
    logic held_v;
    logic acc_h;
    logic [7:0] pix;

    rst = 1'b1; win_valid = 1'b0; coef_we = 1'b0; coef_swap = 1'b0; out_ready = 1'b1;
    coef_addr = '0; coef_wdata = '0;
    for (int i = 0; i < N; i++) win[i] = '0;
    tick(); tick();
    check("reset_win_ready", 32'(win_ready), 0);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_pix", 32'(out_pix), 0);
    rst = 1'b0;
    #1;
    check("win_ready_after_reset", 32'(win_ready), 1);

    // Identity kernel and exact latency.
    for (int i = 0; i < N; i++) kern[i] = (i == 5) ? 16 : 0;
    load_kernel(kern);
    for (int i = 0; i < N; i++) w[i] = 10 * i;
    set_win(w);
    win_valid = 1'b1;
    #1;
    check("identity_ready", 32'(win_ready), 1);
    tick();
    win_valid = 1'b0;
    check("lat_edge_t", 32'(out_valid), 0);
    tick();
    check("lat_edge_t1", 32'(out_valid), 0);
    tick();
    check("lat_edge_t2_valid", 32'(out_valid), 1);
    check("identity_pix", 32'(out_pix), 50);
    tick();
    drain();

    // Clamp high.
    for (int i = 0; i < N; i++) begin kern[i] = 16; w[i] = 255; end
    load_kernel(kern);
    run_one(w, pix);
    check("clamp_high", 32'(pix), 255);

    // Clamp low.
    for (int i = 0; i < N; i++) begin kern[i] = (i == 0) ? -16 : 0; w[i] = $urandom_range(0, 255); end
    w[0] = 10;
    load_kernel(kern);
    run_one(w, pix);
    check("clamp_low", 32'(pix), 0);

    // Rounding boundary.
    for (int i = 0; i < N; i++) begin kern[i] = (i == 5) ? 1 : 0; w[i] = $urandom_range(0, 255); end
    load_kernel(kern);
    w[5] = 8;
    run_one(w, pix);
`ifdef CONV_ROUND_EN
    check("round_8", 32'(pix), 1);
`else
    check("round_8", 32'(pix), 0);
`endif
    w[5] = 7;
    run_one(w, pix);
    check("round_7", 32'(pix), 0);
    drain();

    // Backpressure: 8 windows, out_ready low for 5 cycles mid-stream.
    for (int i = 0; i < N; i++) kern[i] = (i == 5) ? 16 : 0;
    load_kernel(kern);
    d0 = delivered; idx = 0; held_v = 1'b0; held = 0;
    for (int i = 0; i < N; i++) w[i] = $urandom_range(0, 255);
    w[5] = 20;
    set_win(w);
    win_valid = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      #1;
      if (out_valid && !out_ready) begin
        check("bp_win_ready", 32'(win_ready), 0);
        if (held_v) check("bp_hold_pix", 32'(out_pix), held);
        held_v = 1'b1;
        held = int'(out_pix);
      end else begin
        held_v = 1'b0;
      end
      acc_h = win_valid && win_ready;
      tick();
      if (acc_h) begin
        idx++;
        if (idx == 8) win_valid = 1'b0;
        else begin w[5] = 20 + idx; set_win(w); end
      end
    end
    out_ready = 1'b1;
    drain();
    check("bp_delivered", delivered - d0, 8);

    // Swap timing: swap plus a shadow write in the cycle window #3 is accepted.
    for (int i = 0; i < N; i++) kern[i] = (i == 5) ? 16 : 0;
    load_kernel(kern);
    wr(5, 32);
    idx = 0; ng = 0;
    for (int i = 0; i < N; i++) w[i] = $urandom_range(0, 255);
    for (int cyc = 0; cyc < 40 && ng < 8; cyc++) begin
      win_valid = (idx < 8);
      w[5] = 10 + idx;
      set_win(w);
      coef_swap = (idx == 3);
      coef_we = (idx == 3);
      coef_addr = 4'd5;
      coef_wdata = 8'd48;
      #1;
      if (out_valid && out_ready) begin got_pix[ng] = int'(out_pix); ng++; end
      acc_h = win_valid && win_ready;
      tick();
      coef_swap = 1'b0;
      coef_we = 1'b0;
      if (acc_h) idx++;
    end
    win_valid = 1'b0;
    check("swap_count", ng, 8);
    for (int i = 0; i < 8; i++) check($sformatf("swap_win%0d", i), got_pix[i], (i <= 3) ? (10 + i) : 2 * (10 + i));
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
    w[5] = 10;
    run_one(w, pix);
    check("swap_we_next", 32'(pix), 30);
    drain();

    // Reset with three results in flight.
    for (int i = 0; i < N; i++) kern[i] = (i == 5) ? 16 : 0;
    load_kernel(kern);
    out_ready = 1'b0;
    w[5] = 99;
    set_win(w);
    win_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rst_fill_ready", 32'(win_ready), 1);
      tick();
    end
    win_valid = 1'b0;
    check("rst_fill_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_win_ready", 32'(win_ready), 0);
    tick();
    rst = 1'b0;
    check("rst_mid_out_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_no_stale", 32'(out_valid), 0);
    end
    for (int i = 0; i < N; i++) w[i] = 10 * i;
    run_one(w, pix);
    check("rst_coef_zero", 32'(pix), 0);
    drain();

    // Randomized traffic with random coefficient writes, swaps and backpressure.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) w[i] = $urandom_range(0, 255);
      set_win(w);
      win_valid  = ($urandom % 4) != 0;
      out_ready  = ($urandom % 4) != 0;
      coef_we    = ($urandom % 3) == 0;
      coef_addr  = 4'($urandom_range(0, 15));
      coef_wdata = ($urandom % 2) ? 8'($urandom_range(0, 40) - 20) : 8'($urandom);
      coef_swap  = ($urandom % 16) == 0;
      tick();
    end
    win_valid = 1'b0; coef_we = 1'b0; coef_swap = 1'b0; out_ready = 1'b1;
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
